// File: rtl/aclk_pkg.sv
// Shared types, limits and load validation for the alarm-clock time-of-day counter.
package aclk_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t hr_tens;
        bcd_digit_t hr_ones;
        bcd_digit_t min_tens;
        bcd_digit_t min_ones;
    } time_bcd_t;

    localparam int MIN_TENS_MAX = 32'sd5;
    localparam int DIGIT_MAX    = 32'sd9;
    localparam int HR24_MAX     = 32'sd23;
    localparam int HR12_MIN     = 32'sd1;
    localparam int HR12_MAX     = 32'sd12;

    // Digits must all be decimal, minutes below 60, hours inside the mode's range.
    function automatic logic bcd_time_valid(input time_bcd_t t, input int mode);
        int   hours;
        logic digits_ok;
        logic hours_ok;
        digits_ok = (int'(t.hr_tens)  <= DIGIT_MAX) &&
                    (int'(t.hr_ones)  <= DIGIT_MAX) &&
                    (int'(t.min_tens) <= MIN_TENS_MAX) &&
                    (int'(t.min_ones) <= DIGIT_MAX);
        hours = int'(t.hr_tens) * 32'sd10 + int'(t.hr_ones);
        if (mode == 32'sd12) begin
            hours_ok = (hours >= HR12_MIN) && (hours <= HR12_MAX);
        end else begin
            hours_ok = (hours <= HR24_MAX);
        end
        return digits_ok && hours_ok;
    endfunction

endpackage

// File: rtl/aclk_bcd_digit.sv
// Single BCD digit counting 0..MODULUS-1 with synchronous load and wrap carry.
module aclk_bcd_digit #(
    parameter int MODULUS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       carry_out
);

    localparam logic [3:0] LAST = 4'(MODULUS - 1);

    logic [3:0] digit_r;

    // Digit state: a load overrides counting; counting wraps from LAST to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_r <= 4'd0;
        end else if (load) begin
            digit_r <= load_val;
        end else if (enable) begin
            if (digit_r == LAST) begin
                digit_r <= 4'd0;
            end else begin
                digit_r <= digit_r + 4'd1;
            end
        end else begin
            digit_r <= digit_r;
        end
    end

    // Carry is combinational so the next digit advances on the same edge.
    assign carry_out = enable && !load && (digit_r == LAST);
    assign digit     = digit_r;

endmodule

// File: rtl/aclk_time_counter.sv
// Time-of-day counter in packed BCD HH:MM, 24h or 12h+pm, with load checking and rollover strobes.
module aclk_time_counter
    import aclk_pkg::*;
#(
    parameter int HOUR_MODE = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        one_minute,
    input  logic        load_new_c,
    input  logic [15:0] new_time,
    input  logic        new_pm,
    output logic [15:0] current_time,
    output logic        pm,
    output logic        hour_tick,
    output logic        day_wrap,
    output logic        load_err
);

    localparam logic       IS_12H      = (HOUR_MODE == 32'sd12);
    localparam logic [3:0] HR_TENS_RST = IS_12H ? 4'd1 : 4'd0;
    localparam logic [3:0] HR_ONES_RST = IS_12H ? 4'd2 : 4'd0;

    time_bcd_t  new_s;
    logic       load_ok_s;
    logic       valid_load_s;
    logic       inc_s;
    logic       min_carry_s;
    logic       hour_inc_s;
    logic [3:0] min_ones_s;
    logic [3:0] min_tens_s;
    logic [3:0] hr_tens_r;
    logic [3:0] hr_ones_r;
    logic [3:0] hr_tens_nx_s;
    logic [3:0] hr_ones_nx_s;
    logic       pm_r;
    logic       pm_flip_s;
    logic       wrap_day_s;
    logic       hour_tick_r;
    logic       day_wrap_r;
    logic       load_err_r;

    assign new_s        = time_bcd_t'(new_time);
    assign load_ok_s    = bcd_time_valid(new_s, HOUR_MODE);
    assign valid_load_s = load_new_c && load_ok_s;
    // A valid load swallows a coincident minute pulse.
    assign inc_s        = one_minute && !valid_load_s;

    aclk_bcd_digit #(.MODULUS(10)) u_min_ones (
        .clk       (clk),
        .reset     (reset),
        .enable    (inc_s),
        .load      (valid_load_s),
        .load_val  (new_s.min_ones),
        .digit     (min_ones_s),
        .carry_out (min_carry_s)
    );

    aclk_bcd_digit #(.MODULUS(MIN_TENS_MAX + 1)) u_min_tens (
        .clk       (clk),
        .reset     (reset),
        .enable    (min_carry_s),
        .load      (valid_load_s),
        .load_val  (new_s.min_tens),
        .digit     (min_tens_s),
        .carry_out (hour_inc_s)
    );

    // Next hour value for a minute-carry, with the mode-dependent wrap points.
    always_comb begin
        hr_tens_nx_s = hr_tens_r;
        hr_ones_nx_s = hr_ones_r;
        pm_flip_s    = 1'b0;
        wrap_day_s   = 1'b0;
        if (IS_12H) begin
            if ((hr_tens_r == 4'd1) && (hr_ones_r == 4'd2)) begin
                hr_tens_nx_s = 4'd0;
                hr_ones_nx_s = 4'd1;
            end else if ((hr_tens_r == 4'd1) && (hr_ones_r == 4'd1)) begin
                hr_ones_nx_s = 4'd2;
                pm_flip_s    = 1'b1;
                wrap_day_s   = pm_r;
            end else if (hr_ones_r == 4'd9) begin
                hr_tens_nx_s = hr_tens_r + 4'd1;
                hr_ones_nx_s = 4'd0;
            end else begin
                hr_ones_nx_s = hr_ones_r + 4'd1;
            end
        end else begin
            if ((hr_tens_r == 4'd2) && (hr_ones_r == 4'd3)) begin
                hr_tens_nx_s = 4'd0;
                hr_ones_nx_s = 4'd0;
                wrap_day_s   = 1'b1;
            end else if (hr_ones_r == 4'd9) begin
                hr_tens_nx_s = hr_tens_r + 4'd1;
                hr_ones_nx_s = 4'd0;
            end else begin
                hr_ones_nx_s = hr_ones_r + 4'd1;
            end
        end
    end

    // Hour pair, pm flag and output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hr_tens_r   <= HR_TENS_RST;
            hr_ones_r   <= HR_ONES_RST;
            pm_r        <= 1'b0;
            hour_tick_r <= 1'b0;
            day_wrap_r  <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            if (valid_load_s) begin
                hr_tens_r <= new_s.hr_tens;
                hr_ones_r <= new_s.hr_ones;
                pm_r      <= IS_12H ? new_pm : 1'b0;
            end else if (hour_inc_s) begin
                hr_tens_r <= hr_tens_nx_s;
                hr_ones_r <= hr_ones_nx_s;
                pm_r      <= pm_r ^ pm_flip_s;
            end else begin
                hr_tens_r <= hr_tens_r;
                hr_ones_r <= hr_ones_r;
                pm_r      <= pm_r;
            end
            hour_tick_r <= hour_inc_s;
            day_wrap_r  <= hour_inc_s && wrap_day_s;
            load_err_r  <= load_new_c && !load_ok_s;
        end
    end

    assign current_time = {hr_tens_r, hr_ones_r, min_tens_s, min_ones_s};
    assign pm           = pm_r;
    assign hour_tick    = hour_tick_r;
    assign day_wrap     = day_wrap_r;
    assign load_err     = load_err_r;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Bench for aclk_time_counter: 24h and 12h instances against a minutes-of-day model.
module tb_aclk_time_counter;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        one_minute = 1'b0;
    logic        load_new_c = 1'b0;
    logic        new_pm     = 1'b0;
    logic [15:0] new_time   = 16'h0000;

    logic [15:0] t24, t12;
    logic        pm24, pm12, ht24, ht12, dw24, dw12, le24, le12;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state: minutes since midnight (0 = 00:00 / 12:00am) plus expected strobes.
    int m24, m12;
    bit eht24, edw24, ele24, eht12, edw12, ele12;

    aclk_time_counter #(.HOUR_MODE(24)) dut24 (
        .clk(clk), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
        .new_time(new_time), .new_pm(new_pm), .current_time(t24), .pm(pm24),
        .hour_tick(ht24), .day_wrap(dw24), .load_err(le24)
    );

    aclk_time_counter #(.HOUR_MODE(12)) dut12 (
        .clk(clk), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
        .new_time(new_time), .new_pm(new_pm), .current_time(t12), .pm(pm12),
        .hour_tick(ht12), .day_wrap(dw12), .load_err(le12)
    );

    always #5 clk = ~clk;

    function automatic bit load_valid(input logic [15:0] t, input bit is12, input bit p,
                                      output int mins);
        int d3, d2, d1, d0, hh;
        d3 = int'(t[15:12]);
        d2 = int'(t[11:8]);
        d1 = int'(t[7:4]);
        d0 = int'(t[3:0]);
        hh = d3 * 10 + d2;
        if (is12) mins = ((hh % 12) + (p ? 12 : 0)) * 60 + d1 * 10 + d0;
        else      mins = hh * 60 + d1 * 10 + d0;
        if (d3 > 9 || d2 > 9 || d1 > 5 || d0 > 9) return 1'b0;
        if (is12) return (hh >= 1) && (hh <= 12);
        return hh <= 23;
    endfunction

    function automatic logic [15:0] exp_time(input int m, input bit is12);
        int h, mm;
        h  = m / 60;
        mm = m % 60;
        if (is12) begin
            h = h % 12;
            if (h == 0) h = 12;
        end
        return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    task automatic step(input bit is12, inout int m, output bit ht, output bit dw, output bit le);
        int lm;
        bit ok;
        ht = 1'b0;
        dw = 1'b0;
        le = 1'b0;
        ok = load_valid(new_time, is12, new_pm, lm);
        if (load_new_c && ok) begin
            m = lm;
        end else begin
            le = load_new_c;
            if (one_minute) begin
                m  = (m + 1) % 1440;
                ht = (m % 60) == 0;
                dw = (m == 0);
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m24 = 0; m12 = 0;
            eht24 = 0; edw24 = 0; ele24 = 0;
            eht12 = 0; edw12 = 0; ele12 = 0;
        end else begin
            step(1'b0, m24, eht24, edw24, ele24);
            step(1'b1, m12, eht12, edw12, ele12);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("cmp_t24",  t24, exp_time(m24, 1'b0));
            check("cmp_pm24", {15'd0, pm24}, 16'd0);
            check("cmp_ht24", {15'd0, ht24}, {15'd0, eht24});
            check("cmp_dw24", {15'd0, dw24}, {15'd0, edw24});
            check("cmp_le24", {15'd0, le24}, {15'd0, ele24});
            check("cmp_t12",  t12, exp_time(m12, 1'b1));
            check("cmp_pm12", {15'd0, pm12}, {15'd0, m12 >= 720});
            check("cmp_ht12", {15'd0, ht12}, {15'd0, eht12});
            check("cmp_dw12", {15'd0, dw12}, {15'd0, edw12});
            check("cmp_le12", {15'd0, le12}, {15'd0, ele12});
        end
    end

    // Drive one cycle of inputs just after a rising edge; returns just after the sampling edge.
    task automatic tick(input bit om, input bit ld, input logic [15:0] t, input bit p);
        one_minute = om;
        load_new_c = ld;
        new_time   = t;
        new_pm     = p;
        @(posedge clk);
        #1;
        one_minute = 1'b0;
        load_new_c = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_en = 1'b1;
        check("rst_t24", t24, 16'h0000);
        check("rst_t12", t12, 16'h1200);
        check("rst_pm12", {15'd0, pm12}, 16'd0);
        check("rst_strobes", {12'd0, ht24, dw24, le24, ht12}, 16'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 16'h0000, 1'b0);
        check("nine_pulses", t24, 16'h0009);
        tick(1'b1, 1'b0, 16'h0000, 1'b0);
        check("tenth_pulse", t24, 16'h0010);
        check("tenth_no_ht", {15'd0, ht24}, 16'd0);

        tick(1'b0, 1'b1, 16'h0059, 1'b0);
        tick(1'b1, 1'b0, 16'h0000, 1'b0);
        check("t_0100", t24, 16'h0100);
        check("ht_0100", {15'd0, ht24}, 16'd1);
        tick(1'b0, 1'b0, 16'h0000, 1'b0);
        check("ht_one_cycle", {15'd0, ht24}, 16'd0);

        tick(1'b0, 1'b1, 16'h2359, 1'b0);
        tick(1'b1, 1'b0, 16'h0000, 1'b0);
        check("day_t", t24, 16'h0000);
        check("day_ht_dw", {14'd0, ht24, dw24}, 16'd3);

        tick(1'b0, 1'b1, 16'h2400, 1'b0);
        check("bad_2400", {le24, t24[14:0]}, 16'h8000);
        tick(1'b0, 1'b1, 16'h0160, 1'b0);
        check("bad_0160", {le24, t24[14:0]}, 16'h8000);
        tick(1'b0, 1'b1, 16'h001A, 1'b0);
        check("bad_001A", {le24, t24[14:0]}, 16'h8000);
        tick(1'b0, 1'b1, 16'h1234, 1'b0);
        check("load_1234", t24, 16'h1234);
        check("load_1234_le", {15'd0, le24}, 16'd0);

        tick(1'b1, 1'b1, 16'h0500, 1'b0);
        check("load_wins", t24, 16'h0500);
        check("load_wins_strobes", {13'd0, ht24, dw24, le24}, 16'd0);
        tick(1'b1, 1'b1, 16'h9999, 1'b0);
        check("bad_plus_inc", t24, 16'h0501);
        check("bad_plus_inc_le", {15'd0, le24}, 16'd1);

        tick(1'b0, 1'b1, 16'h1159, 1'b0);
        tick(1'b1, 1'b0, 16'h0000, 1'b0);
        check("h12_noon_t", t12, 16'h1200);
        check("h12_noon_pm_dw", {14'd0, pm12, dw12}, 16'd2);
        tick(1'b0, 1'b1, 16'h1259, 1'b0);
        tick(1'b1, 1'b0, 16'h0000, 1'b0);
        check("h12_one", t12, 16'h0100);
        tick(1'b0, 1'b1, 16'h1159, 1'b1);
        tick(1'b1, 1'b0, 16'h0000, 1'b0);
        check("h12_midnight_t", t12, 16'h1200);
        check("h12_midnight_pm_dw", {14'd0, pm12, dw12}, 16'd1);

        tick(1'b0, 1'b1, 16'h0000, 1'b0);
        one_minute = 1'b1;
        repeat (3) @(posedge clk);
        #1 one_minute = 1'b0;
        check("held_three", t24, 16'h0003);

        tick(1'b0, 1'b1, 16'h1547, 1'b0);
        one_minute = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_t24", t24, 16'h0000);
        check("async_t12", t12, 16'h1200);
        check("async_strobes", {12'd0, ht24, dw24, le24, pm12}, 16'd0);
        @(posedge clk); #1;
        one_minute = 1'b0;
        reset = 1'b0;
        tick(1'b1, 1'b0, 16'h0000, 1'b0);
        check("resume_t24", t24, 16'h0001);
        check("resume_t12", t12, 16'h1201);

        tick(1'b0, 1'b0, 16'h0000, 1'b0);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aclk_time_counter.md
Name: aclk_time_counter

Overview:
- Time-of-day counter for the alarm clock; consumes the one_minute strobe from the time generator and keeps current time as packed BCD HH:MM.
- Supports synchronous loading of a user-set time from the keypad/register path.
- Output feeds the display driver and the alarm comparator.
- Flags an invalid load and produces hour and day rollover strobes for downstream logic.

Parameters:
- HOUR_MODE, 24, clock format: 24 gives range 00:00-23:59; 12 gives range 01:00-12:59 with a pm flag.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- one_minute  input  1  single-cycle minute strobe from the time generator
- load_new_c  input  1  single-cycle request to load new_time
- new_time  input  16  packed BCD {hr_tens, hr_ones, min_tens, min_ones}
- new_pm  input  1  pm flag to load; ignored when HOUR_MODE=24
- current_time  output  16  packed BCD current time, same layout as new_time
- pm  output  1  afternoon flag; constant 0 when HOUR_MODE=24
- hour_tick  output  1  one-cycle strobe when minutes wrap 59->00
- day_wrap  output  1  one-cycle strobe on 23:59->00:00 (24h) or 11:59pm->12:00am (12h)
- load_err  output  1  one-cycle strobe on a rejected load

Behaviour:
- Reset values:
  - current_time = 16'h0000 (24h) or 16'h1200 (12h).
  - pm = 0; hour_tick = 0; day_wrap = 0; load_err = 0.
- Reset is asynchronous and takes effect mid-operation; it abandons any in-flight increment.
- All outputs are registered. current_time reflects a sampled event one cycle after the clk edge that sampled one_minute or load_new_c.
- Load validation (combinational on new_time):
  - Every digit must be <= 9.
  - min_tens <= 5.
  - 24h mode: hours in 00..23.
  - 12h mode: hours in 01..12.
- Priority, highest first: reset, valid load, one_minute.
  - Valid load with one_minute in the same cycle: the loaded value wins and the minute is dropped; no hour_tick or day_wrap.
  - Invalid load with one_minute in the same cycle: load_err=1 and the increment is still applied.
  - Invalid load alone: load_err=1 and time is unchanged.
- Minute increment:
  - min_ones 0-9; on 9->0 it carries into min_tens.
  - min_tens 0-5; on 5->0 it carries into hours and asserts hour_tick.
- 24h hour increment:
  - hr_ones 9->0 carries into hr_tens.
  - 23 -> 00 asserts day_wrap; hour_tick is also 1 in that cycle.
- 12h hour increment:
  - 12 -> 01.
  - 11 -> 12 toggles pm.
  - The 11->12 transition with pm going 1->0 asserts day_wrap.
- Strobes are 1 for exactly one cycle and 0 otherwise. Back-to-back one_minute pulses (fast mode, one per 256 clocks or closer) must each be counted; the design needs no minimum spacing.
- one_minute held high for N consecutive cycles gives N increments.
- Any strobe that would coincide with reset is 0.

Decomposition:
- Package aclk_pkg:
  - bcd_digit_t (4-bit) typedef.
  - time_bcd_t struct {hr_tens, hr_ones, min_tens, min_ones}.
  - Constants MIN_TENS_MAX=5, DIGIT_MAX=9, HR24_MAX=23, HR12_MIN=1, HR12_MAX=12.
  - Function bcd_time_valid(time, mode).
- Sub-module aclk_bcd_digit:
  - Parameterised modulo/limit BCD digit with enable, synchronous load and carry_out.
  - Instantiated for min_ones (mod 10) and min_tens (mod 6).
  - Hour pair stays in the parent because of the mode-dependent 23/12 wrap.

Test Plan:
- Reset, then 9 one_minute pulses -> current_time=16'h0009; 10th pulse -> 16'h0010 with no hour_tick.
- Load 16'h0059, one pulse -> 16'h0100 with hour_tick=1 for one cycle; load 16'h2359, one pulse -> 16'h0000 with hour_tick=1 and day_wrap=1 in the same cycle.
- Invalid loads 16'h2400, 16'h0160 and 16'h001A -> load_err=1 for one cycle each, current_time unchanged; load 16'h1234 -> 16'h1234, load_err=0.
- Load 16'h0500 together with one_minute in the same cycle -> 16'h0500 with no strobes; invalid load 16'h9999 together with one_minute from 16'h0500 -> 16'h0501 and load_err=1.
- HOUR_MODE=12:
  - Reset -> 16'h1200, pm=0.
  - Load 16'h1159, pm=0, one pulse -> 16'h1200, pm=1, day_wrap=0.
  - Load 16'h1259, one pulse -> 16'h0100.
  - Load 16'h1159 with new_pm=1, one pulse -> 16'h1200, pm=0, day_wrap=1.
- From 16'h0000, one_minute held for 3 consecutive cycles -> 16'h0003; assert reset mid-stream at 16'h1547 -> outputs 0 immediately (asynchronously), counting resumes from 16'h0000 after release.
